// File: rtl/psram_pkg.sv
// Shared constants for the serial PSRAM controller:
// command opcodes, frame lengths and FSM state encodings.
package psram_pkg;

    localparam logic [7:0] CMD_READ    = 8'h03;
    localparam logic [7:0] CMD_WRITE   = 8'h02;
    localparam logic [7:0] CMD_RST_EN  = 8'h66;
    localparam logic [7:0] CMD_RST     = 8'h99;
    localparam logic [7:0] CMD_READ_ID = 8'h9F;

    localparam logic [5:0] FRAME_BITS      = 6'd40;
    localparam logic [5:0] INIT_FRAME_BITS = 6'd8;

    localparam logic [2:0] ST_POWERUP = 3'd0;
    localparam logic [2:0] ST_RSTEN   = 3'd1;
    localparam logic [2:0] ST_RST     = 3'd2;
    localparam logic [2:0] ST_GAP     = 3'd3;
    localparam logic [2:0] ST_IDLE    = 3'd4;
    localparam logic [2:0] ST_XFER    = 3'd5;

    // Short command frames are left-aligned so the shifter always
    // starts from bit 39.
    function automatic logic [39:0] init_frame(input logic [7:0] cmd);
        return {cmd, 32'h0};
    endfunction

endpackage

// File: rtl/psram_spi_shifter.sv
// SPI mode-0 frame shifter: two CLK cycles per bit, MSB first,
// registered pins, captures the trailing data byte of read frames.
module psram_spi_shifter (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [39:0] frame,
    input  logic [5:0]  nbits,
    input  logic        rx_en,
    output logic        ram_clk,
    output logic        ram_ce_b,
    output logic        ram_si,
    input  logic        ram_so,
    output logic        done,
    output logic [7:0]  rx
);

    logic [38:0] sr;
    logic [5:0]  bit_cnt;
    logic        phase;
    logic        busy;
    logic        rx_en_q;
    logic [6:0]  rx_sr;

    // Bit sequencer: phase 0 presents the bit, phase 1 raises the clock;
    // the edge ending phase 1 samples MISO and advances to the next bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr       <= '0;
            bit_cnt  <= '0;
            phase    <= 1'b0;
            busy     <= 1'b0;
            rx_en_q  <= 1'b0;
            rx_sr    <= '0;
            rx       <= '0;
            done     <= 1'b0;
            ram_clk  <= 1'b0;
            ram_ce_b <= 1'b1;
            ram_si   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                sr       <= frame[38:0];
                bit_cnt  <= nbits - 6'd1;
                phase    <= 1'b0;
                busy     <= 1'b1;
                rx_en_q  <= rx_en;
                ram_ce_b <= 1'b0;
                ram_clk  <= 1'b0;
                ram_si   <= frame[39];
            end else if (busy) begin
                if (!phase) begin
                    ram_clk <= 1'b1;
                    phase   <= 1'b1;
                end else begin
                    ram_clk <= 1'b0;
                    phase   <= 1'b0;
                    // The last eight bits of a 40-bit frame carry read data.
                    if (rx_en_q && bit_cnt < 6'd8)
                        rx_sr <= {rx_sr[5:0], ram_so};
                    if (bit_cnt == 6'd0) begin
                        ram_ce_b <= 1'b1;
                        ram_si   <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        if (rx_en_q)
                            rx <= {rx_sr, ram_so};
                    end else begin
                        ram_si  <= sr[38];
                        sr      <= {sr[37:0], 1'b0};
                        bit_cnt <= bit_cnt - 6'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/psram_spi_ctrl.sv
// PSRAM sequencer: power-up wait, reset-enable/reset commands,
// then single-byte read/write requests over a valid/ready handshake.
module psram_spi_ctrl
    import psram_pkg::*;
#(
    parameter int POWERUP_CYCLES = 7500,
    parameter int CE_HIGH_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        init_done,
    output logic        RAM_CLK,
    output logic        RAM_CE_B,
    output logic        RAM_SI,
    input  logic        RAM_SO
);

    localparam int PW = $clog2(POWERUP_CYCLES + 1);
    localparam int GW = $clog2(CE_HIGH_CYCLES + 1);
    // The done cycle already has CE_B high, so the gap state
    // itself only needs to cover the remaining cycles.
    localparam logic [GW-1:0] GAP_INIT = GW'(CE_HIGH_CYCLES - 1);
    localparam logic [PW-1:0] PWR_LAST = PW'(POWERUP_CYCLES - 1);

    logic [2:0]    state;
    logic [2:0]    ret;
    logic [PW-1:0] pwr_cnt;
    logic [GW-1:0] gap_cnt;
    logic          wr_q;

    logic          load;
    logic [39:0]   frame;
    logic [5:0]    nbits;
    logic          rx_en;
    logic          done;
    logic [7:0]    rx;
    logic          accept;
    logic          pwr_end;
    logic          gap_end;

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_ready && req_valid;
    assign pwr_end   = (state == ST_POWERUP) && (pwr_cnt == PWR_LAST);
    assign gap_end   = (state == ST_GAP) && (gap_cnt <= GW'(1));
    assign rsp_valid = done && (state == ST_XFER) && !wr_q;
    assign rsp_rdata = rx;

    // Frames launch on the same edge the FSM leaves its wait state,
    // so CE_B falls the cycle after an accept.
    always_comb begin
        load  = 1'b0;
        frame = '0;
        nbits = INIT_FRAME_BITS;
        rx_en = 1'b0;
        if (pwr_end) begin
            load  = 1'b1;
            frame = init_frame(CMD_RST_EN);
        end else if (gap_end && ret == ST_RST) begin
            load  = 1'b1;
            frame = init_frame(CMD_RST);
        end else if (accept) begin
            load  = 1'b1;
            frame = {req_write ? CMD_WRITE : CMD_READ, req_addr,
                     req_write ? req_wdata : 8'h00};
            nbits = FRAME_BITS;
            rx_en = !req_write;
        end
    end

    // Sequencing FSM with power-up and chip-select gap counters.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= ST_POWERUP;
            ret       <= ST_IDLE;
            pwr_cnt   <= '0;
            gap_cnt   <= '0;
            wr_q      <= 1'b0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_POWERUP: begin
                    if (pwr_end)
                        state <= ST_RSTEN;
                    else
                        pwr_cnt <= pwr_cnt + PW'(1);
                end
                ST_RSTEN: begin
                    if (done) begin
                        state   <= ST_GAP;
                        ret     <= ST_RST;
                        gap_cnt <= GAP_INIT;
                    end
                end
                ST_RST, ST_XFER: begin
                    if (done) begin
                        state   <= ST_GAP;
                        ret     <= ST_IDLE;
                        gap_cnt <= GAP_INIT;
                    end
                end
                ST_GAP: begin
                    if (gap_end) begin
                        if (ret == ST_RST) begin
                            state <= ST_RST;
                        end else begin
                            state     <= ST_IDLE;
                            init_done <= 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        wr_q  <= req_write;
                        state <= ST_XFER;
                    end
                end
                default: state <= ST_POWERUP;
            endcase
        end
    end

    psram_spi_shifter u_shifter (
        .clk      (CLK),
        .rst      (RESET),
        .load     (load),
        .frame    (frame),
        .nbits    (nbits),
        .rx_en    (rx_en),
        .ram_clk  (RAM_CLK),
        .ram_ce_b (RAM_CE_B),
        .ram_si   (RAM_SI),
        .ram_so   (RAM_SO),
        .done     (done),
        .rx       (rx)
    );

endmodule

// File: tb/tb_psram_spi_ctrl.sv
// Directed bench for psram_spi_ctrl with a behavioural PSRAM model:
// init sequence, read/write frames, back-to-back, reset abort, wrap.
module tb_psram_spi_ctrl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [23:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        init_done;
    logic        RAM_CLK;
    logic        RAM_CE_B;
    logic        RAM_SI;
    logic        RAM_SO = 1'b0;

    psram_spi_ctrl #(
        .POWERUP_CYCLES (16),
        .CE_HIGH_CYCLES (4)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .RAM_CLK   (RAM_CLK),
        .RAM_CE_B  (RAM_CE_B),
        .RAM_SI    (RAM_SI),
        .RAM_SO    (RAM_SO)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // PSRAM model: shifts MOSI on RAM_CLK rise, drives read data
    // after RAM_CLK falls, commits writes when CE_B rises.
    int          nedges = 0;
    logic [39:0] sh = '0;
    logic [39:0] last_frame = '0;
    int          last_edges = 0;
    logic        is_rd = 1'b0;
    logic [7:0]  rd_byte = '0;
    logic [7:0]  mem [int];

    always @(negedge RAM_CE_B) begin
        nedges = 0;
        sh = '0;
        is_rd = 1'b0;
    end

    always @(posedge RAM_CLK) begin
        if (!RAM_CE_B) begin
            sh = {sh[38:0], RAM_SI};
            nedges++;
        end
    end

    always @(posedge RAM_CE_B) begin
        last_frame = sh;
        last_edges = nedges;
        if (nedges == 40 && sh[39:32] == 8'h02)
            mem[int'(sh[31:8])] = sh[7:0];
    end

    always @(negedge RAM_CLK) begin
        #1;
        if (!RAM_CE_B) begin
            if (nedges == 32) begin
                is_rd = (sh[31:24] == 8'h03);
                rd_byte = mem.exists(int'(sh[23:0])) ?
                          mem[int'(sh[23:0])] : 8'h00;
            end
            if (is_rd && nedges >= 32 && nedges < 40)
                RAM_SO = rd_byte[3'(39 - nedges)];
        end
    end

    // Response and chip-select monitor.
    int   rsp_cnt = 0;
    int   rsp_cyc = 0;
    logic [7:0] rsp_dat = '0;
    int   last_rise = 0;
    int   last_fall = 0;
    logic ce_q = 1'b1;

    always @(negedge CLK) begin
        if (rsp_valid) begin
            rsp_cnt++;
            rsp_cyc = cyc;
            rsp_dat = rsp_rdata;
            check("rsp_with_ready", req_ready, 1'b0);
        end
        if (RAM_CE_B && !ce_q) last_rise = cyc;
        if (!RAM_CE_B && ce_q) last_fall = cyc;
        ce_q = RAM_CE_B;
    end

    task automatic wait_ce(input logic lvl, input string name,
                           output int c);
        bit ok = 1'b0;
        c = cyc;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge CLK);
            if (RAM_CE_B == lvl) begin
                ok = 1'b1;
                c = cyc;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s timeout waiting CE_B=%0b", name, lvl);
        end
    endtask

    task automatic wait_rdy(input string name, output int c);
        bit ok = 1'b0;
        c = cyc;
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                c = cyc;
            end else begin
                @(negedge CLK);
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s timeout waiting req_ready", name);
        end
    endtask

    // Called on the negedge where RESET has just been released.
    task automatic run_init(input string tag);
        int r, f, c, q;
        r = cyc;
        wait_ce(1'b0, {tag, "_pwr"}, f);
        check({tag, "_powerup_len"}, 64'(f - r), 64'd16);
        wait_ce(1'b1, {tag, "_rsten"}, c);
        check({tag, "_rsten_len"}, 64'(c - f), 64'd16);
        check({tag, "_rsten_cmd"}, last_frame[7:0], 8'h66);
        check({tag, "_rsten_edges"}, last_edges, 8);
        check({tag, "_done_early"}, init_done, 1'b0);
        wait_ce(1'b0, {tag, "_gap"}, f);
        check({tag, "_gap_len"}, 64'(f - c), 64'd4);
        wait_ce(1'b1, {tag, "_rst"}, c);
        check({tag, "_rst_cmd"}, last_frame[7:0], 8'h99);
        check({tag, "_rst_edges"}, last_edges, 8);
        wait_rdy({tag, "_ready"}, q);
        check({tag, "_ready_delay"}, 64'(q - c), 64'd4);
        check({tag, "_init_done"}, init_done, 1'b1);
    endtask

    // Issues one request and holds it until accepted; returns accept cycle.
    task automatic issue(input logic wr, input logic [23:0] a,
                         input logic [7:0] d, output int t);
        @(negedge CLK);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        wait_rdy("accept", t);
        @(negedge CLK);
        req_valid = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [23:0] addr;
        logic [7:0]  wdata;
        logic        pre;
        logic [7:0]  pre_val;
        logic [39:0] frame;
        logic        rsp;
        logic [7:0]  rdata;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int t, f, c, q, base, t1, t2;

        vecs[0] = '{1, 24'h012345, 8'hA5, 0, 8'h00, 40'h02012345A5, 0, 8'h00};
        vecs[1] = '{0, 24'h012345, 8'h00, 0, 8'h00, 40'h0301234500, 1, 8'hA5};
        vecs[2] = '{0, 24'hFFFFFF, 8'h00, 1, 8'h3C, 40'h03FFFFFF00, 1, 8'h3C};
        vecs[3] = '{1, 24'h000000, 8'h5A, 0, 8'h00, 40'h020000005A, 0, 8'h00};
        vecs[4] = '{0, 24'h000000, 8'h00, 0, 8'h00, 40'h0300000000, 1, 8'h5A};
        vecs[5] = '{0, 24'h800001, 8'h00, 1, 8'h81, 40'h0380000100, 1, 8'h81};
        vecs[6] = '{1, 24'h555555, 8'hC3, 0, 8'h00, 40'h02555555C3, 0, 8'h00};
        vecs[7] = '{0, 24'h555555, 8'h00, 0, 8'h00, 40'h0355555500, 1, 8'hC3};

        repeat (3) @(negedge CLK);
        check("rst_ce_b", RAM_CE_B, 1'b1);
        check("rst_ram_clk", RAM_CLK, 1'b0);
        check("rst_si", RAM_SI, 1'b0);
        check("rst_ready", req_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rdata", rsp_rdata, 8'h00);
        check("rst_init_done", init_done, 1'b0);
        RESET = 1'b0;
        run_init("init");

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].pre)
                mem[int'(vecs[i].addr)] = vecs[i].pre_val;
            base = rsp_cnt;
            issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, t);
            check($sformatf("v%0d_ce_fall", i), RAM_CE_B, 1'b0);
            wait_ce(1'b1, $sformatf("v%0d_end", i), c);
            check($sformatf("v%0d_ce_rise", i), 64'(c - t), 64'd81);
            check($sformatf("v%0d_frame", i), last_frame, vecs[i].frame);
            check($sformatf("v%0d_edges", i), last_edges, 40);
            wait_rdy($sformatf("v%0d_ready", i), q);
            check($sformatf("v%0d_ready_at", i), 64'(q - t), 64'd85);
            check($sformatf("v%0d_rsp_cnt", i), rsp_cnt - base,
                  vecs[i].rsp ? 1 : 0);
            if (vecs[i].rsp) begin
                check($sformatf("v%0d_rsp_at", i), 64'(rsp_cyc - t), 64'd81);
                check($sformatf("v%0d_rdata", i), rsp_dat, vecs[i].rdata);
            end
        end

        // Back-to-back: valid stays high across write then read.
        base = rsp_cnt;
        @(negedge CLK);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 24'h00ABCD;
        req_wdata = 8'h96;
        wait_rdy("b2b_first", t1);
        @(negedge CLK);
        req_write = 1'b0;
        req_wdata = 8'h00;
        wait_rdy("b2b_second", t2);
        check("b2b_accept_gap", 64'(t2 - t1), 64'd85);
        @(negedge CLK);
        req_valid = 1'b0;
        @(negedge CLK);
        check("b2b_ce_gap_ge4", 64'(last_fall - last_rise >= 4), 64'd1);
        wait_ce(1'b1, "b2b_end", c);
        wait_rdy("b2b_ready", q);
        check("b2b_rsp_cnt", rsp_cnt - base, 1);
        check("b2b_rdata", rsp_dat, 8'h96);

        // Reset in the middle of a read frame.
        base = rsp_cnt;
        issue(1'b0, 24'h012345, 8'h00, t);
        for (int i = 0; i < 200 && cyc < t + 30; i++) @(negedge CLK);
        RESET = 1'b1;
        #1;
        check("abort_ce_b", RAM_CE_B, 1'b1);
        check("abort_ram_clk", RAM_CLK, 1'b0);
        check("abort_init_done", init_done, 1'b0);
        check("abort_ready", req_ready, 1'b0);
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        run_init("reinit");
        check("abort_no_rsp", rsp_cnt - base, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/psram_spi_ctrl.md
Name: psram_spi_ctrl

Overview:
- Sequencer for the serial PSRAM on the SPI pins (RAM_CLK, RAM_CE_B, RAM_SI, RAM_SO).
- After reset it runs the power-up init sequence: wait, then Reset-Enable 0x66, then Reset 0x99.
- It then serves single-byte read (0x03) and write (0x02) requests from one requester through a valid/ready handshake.
- It sits between the SoC logic and the PSRAM pins and replaces any free-running SPI test logic.

Parameters:
- POWERUP_CYCLES, 7500, CLK cycles held idle after reset before the first command (150 us at 50 MHz).
- CE_HIGH_CYCLES, 4, minimum CLK cycles RAM_CE_B stays high between frames.

Ports:
- CLK  in  1  system clock (PLL output, 50 MHz).
- RESET  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller accepts a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  24  byte address.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle pulse: rsp_rdata holds read data.
- rsp_rdata  out  8  last read byte; held until the next read completes.
- init_done  out  1  high once the init sequence is finished; stays high until reset.
- RAM_CLK  out  1  SPI clock (mode 0), CLK/2.
- RAM_CE_B  out  1  chip enable, active-low.
- RAM_SI  out  1  MOSI.
- RAM_SO  in  1  MISO.

Behaviour:
- Reset (async, active-high) forces these values regardless of state: RAM_CE_B=1, RAM_CLK=0, RAM_SI=0, req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0, state=POWERUP. Counters clear.
- Reset during a frame aborts it immediately: CE_B goes high, no response is issued, init reruns.
- All pin outputs are registered; RAM_CLK is not gated from CLK.
- States and transitions:
  - POWERUP: count POWERUP_CYCLES, then go to RSTEN.
  - RSTEN: 8-bit frame 0x66, then GAP.
  - GAP (after RSTEN): then RST.
  - RST: 8-bit frame 0x99, then GAP.
  - GAP (after RST): set init_done, then IDLE.
  - IDLE: req_ready=1. On req_valid&req_ready, latch write/addr/wdata, drop req_ready next cycle, go to XFER.
  - XFER: 40-bit frame {cmd, addr[23:0], wdata or 8'h00}, MSB first, then GAP.
  - GAP: RAM_CE_B high for CE_HIGH_CYCLES, then IDLE (or the next init state).
- Bit timing, two CLK cycles per bit:
  - Phase 0: RAM_CLK=0, RAM_SI=current bit.
  - Phase 1: RAM_CLK=1, RAM_SI held.
  - RAM_SO is sampled on the CLK edge that ends phase 1, only for frame bits 32..39. It is shifted into rdata MSB first.
- Read latency: accept at cycle T.
  - RAM_CE_B falls at T+1.
  - Last phase 1 ends at T+80; RAM_CE_B rises at T+81.
  - rsp_valid=1 for exactly cycle T+81; rsp_rdata updated the same cycle.
  - req_ready returns at T+81+CE_HIGH_CYCLES.
- Writes produce no rsp_valid. Their timing is identical otherwise.
- req_valid while req_ready=0 is ignored; the requester must hold the request.
- rsp_valid never coincides with req_ready=1.
- Counter widths:
  - power-up counter: $clog2(POWERUP_CYCLES+1);
  - bit counter: 6 bits;
  - gap counter: $clog2(CE_HIGH_CYCLES+1).
- Address wraps naturally at 24 bits; the controller applies no checks.

Decomposition:
- Package psram_pkg:
  - CMD_READ=8'h03, CMD_WRITE=8'h02, CMD_RST_EN=8'h66, CMD_RST=8'h99, CMD_READ_ID=8'h9F;
  - FRAME_BITS=40, INIT_FRAME_BITS=8;
  - state encoding constants.
- Sub-module psram_spi_shifter: takes load, frame[39:0], nbits.
  - Drives RAM_CLK/RAM_SI/RAM_CE_B and captures RAM_SO.
  - Outputs done (one-cycle pulse) and rx[7:0].
- psram_spi_ctrl holds only the sequencing FSM, counters and handshake.

Test Plan:
- Init (POWERUP_CYCLES=16, CE_HIGH_CYCLES=4), RESET pulse -> CE_B stays high for 16 cycles.
  - Then frame 0x66, high gap of at least 4 cycles, frame 0x99.
  - init_done=1 and req_ready=1 after the final gap; exactly 8 RAM_CLK rising edges per init frame.
- Write req_addr=24'h012345, req_wdata=8'hA5 -> PSRAM model receives bits 02 01 23 45 A5 MSB-first on RAM_CLK rising.
  - Exactly 40 RAM_CLK edges; no rsp_valid; req_ready back 85 cycles after accept.
- Read of 24'h012345 (model holds A5) -> frame 03 01 23 45 00 sent.
  - rsp_valid pulses once at T+81 with rsp_rdata=8'hA5.
- Back-to-back: req_valid held high for a write then a read -> second accept no earlier than the cycle req_ready returns.
  - CE_B high for at least 4 cycles between frames; read returns the written byte.
- Reset mid-read (RESET at T+30) -> CE_B=1 and RAM_CLK=0 immediately, no rsp_valid, init_done=0.
  - Full init sequence repeats.
- Address wrap: read 24'hFFFFFF -> address bits FF FF FF sent; model data 8'h3C returned correctly.
